// File: rtl/tx_iq_byte_assembler.sv
// Packs a Tx byte stream (six bytes, MSB first, I then Q) into 24-bit I/Q samples served on DUC request.
// One-deep pending sample decouples FIFO collection from sample_req; flush on run low or after reset.
module tx_iq_byte_assembler #(
   parameter int UF_HOLD = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_run,
   input  logic [7:0]  i_fifo_rdata,
   input  logic        i_fifo_empty,
   output logic        o_fifo_rdreq,
   input  logic        i_sample_req,
   output logic [23:0] o_i_out,
   output logic [23:0] o_q_out,
   output logic        o_sample_valid,
   output logic        o_underflow,
   output logic [15:0] o_underflow_count,
   output logic        o_waiting
);

   typedef enum logic {
      S_FLUSH   = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [2:0]  r_idx;
   logic [7:0]  r_b0;
   logic [7:0]  r_b1;
   logic [7:0]  r_b2;
   logic [7:0]  r_b3;
   logic [7:0]  r_b4;
   logic [23:0] r_pi;
   logic [23:0] r_pq;
   logic        r_pv;
   logic [23:0] r_i_out;
   logic [23:0] r_q_out;
   logic        r_sample_valid;
   logic        r_underflow;
   logic [15:0] r_uf_cnt;

   logic        w_flush;
   logic        w_last;
   logic        w_xfer;
   logic        w_rdreq;

   // Dropping run flushes on the very next edge, so the dropping cycle already behaves as flush.
   always_comb begin
      w_flush = (r_state == S_FLUSH) || !i_run;
      w_last  = (r_idx == 3'd5);
      w_xfer  = !w_flush && i_sample_req && r_pv;
      w_rdreq = 1'b0;
      if (!i_fifo_empty) begin
         if (w_flush || !w_last) begin
            w_rdreq = 1'b1;
         end else begin
            w_rdreq = !r_pv || w_xfer;
         end
      end
   end

   assign o_fifo_rdreq = w_rdreq & i_rst_n;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FLUSH:   if (i_run && i_fifo_empty) w_state_nxt = S_COLLECT;
         S_COLLECT: if (!i_run) w_state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_FLUSH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx          <= 3'd0;
         r_b0           <= 8'h00;
         r_b1           <= 8'h00;
         r_b2           <= 8'h00;
         r_b3           <= 8'h00;
         r_b4           <= 8'h00;
         r_pi           <= 24'h0;
         r_pq           <= 24'h0;
         r_pv           <= 1'b0;
         r_i_out        <= 24'h0;
         r_q_out        <= 24'h0;
         r_sample_valid <= 1'b0;
         r_underflow    <= 1'b0;
         r_uf_cnt       <= 16'h0;
      end else if (w_flush) begin
         // Requests during flush are answered with zeros and are not counted.
         r_idx          <= 3'd0;
         r_pv           <= 1'b0;
         r_i_out        <= 24'h0;
         r_q_out        <= 24'h0;
         r_sample_valid <= i_sample_req;
         r_underflow    <= i_sample_req;
      end else begin
         r_sample_valid <= i_sample_req;
         r_underflow    <= i_sample_req && !r_pv;
         if (i_sample_req) begin
            if (r_pv) begin
               r_i_out <= r_pi;
               r_q_out <= r_pq;
            end else begin
               if (UF_HOLD == 0) begin
                  r_i_out <= 24'h0;
                  r_q_out <= 24'h0;
               end
               if (r_uf_cnt != 16'hFFFF) begin
                  r_uf_cnt <= r_uf_cnt + 16'd1;
               end
            end
         end
         if (w_xfer) begin
            r_pv <= 1'b0;
         end
         if (w_rdreq) begin
            case (r_idx)
               3'd0: r_b0 <= i_fifo_rdata;
               3'd1: r_b1 <= i_fifo_rdata;
               3'd2: r_b2 <= i_fifo_rdata;
               3'd3: r_b3 <= i_fifo_rdata;
               3'd4: r_b4 <= i_fifo_rdata;
               default: ;
            endcase
            if (w_last) begin
               // Reload wins over the transfer clear when both land on this edge.
               r_pi  <= {r_b0, r_b1, r_b2};
               r_pq  <= {r_b3, r_b4, i_fifo_rdata};
               r_pv  <= 1'b1;
               r_idx <= 3'd0;
            end else begin
               r_idx <= r_idx + 3'd1;
            end
         end
      end
   end

   assign o_i_out           = r_i_out;
   assign o_q_out           = r_q_out;
   assign o_sample_valid    = r_sample_valid;
   assign o_underflow       = r_underflow;
   assign o_underflow_count = r_uf_cnt;
   assign o_waiting         = !r_pv && (r_idx == 3'd0) && i_fifo_empty && i_run;

endmodule

// File: tb/tb_tx_iq_byte_assembler.sv
// Scoreboarded bench: two instances (zero and hold underflow policy) share one FIFO model and stimulus.
module tb_tx_iq_byte_assembler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        sample_req;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        fifo_empty = 1'b1;

   logic        rdreq0, rdreq1;
   logic [23:0] i0, q0, i1, q1;
   logic        sv0, sv1, uf0, uf1, wt0, wt1;
   logic [15:0] cnt0, cnt1;

   typedef struct packed {
      logic        uf;
      logic [23:0] i0;
      logic [23:0] q0;
      logic [23:0] i1;
      logic [23:0] q1;
      logic [31:0] cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m_e;
   logic [7:0]  fq[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          viol = 0;
   logic [31:0] cyc = 32'd0;
   logic [23:0] h_i = 24'h0;
   logic [23:0] h_q = 24'h0;

   tx_iq_byte_assembler #(.UF_HOLD(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
      .i_fifo_rdata(fifo_rdata), .i_fifo_empty(fifo_empty), .o_fifo_rdreq(rdreq0),
      .i_sample_req(sample_req), .o_i_out(i0), .o_q_out(q0),
      .o_sample_valid(sv0), .o_underflow(uf0), .o_underflow_count(cnt0), .o_waiting(wt0)
   );

   tx_iq_byte_assembler #(.UF_HOLD(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
      .i_fifo_rdata(fifo_rdata), .i_fifo_empty(fifo_empty), .o_fifo_rdreq(rdreq1),
      .i_sample_req(sample_req), .o_i_out(i1), .o_q_out(q1),
      .o_sample_valid(sv1), .o_underflow(uf1), .o_underflow_count(cnt1), .o_waiting(wt1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Show-ahead FIFO model: pops on rdreq at the edge, refreshes its outputs just after.
   always @(posedge clk) begin
      if (rdreq0 && fifo_empty) viol++;
      if (rdreq0 && fq.size() > 0) void'(fq.pop_front());
      #1;
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() == 0) ? 8'h00 : fq[0];
   end

   always @(negedge clk) begin
      if (rst_n && (sv0 || sv1)) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got sample_valid at cycle %0d, expected none", cyc);
         end else begin
            m_e = exp_q.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(m_e.cyc));
            chk("valid_both", 64'({sv0, sv1}), 64'(2'b11));
            chk("zero_policy_out", 64'({uf0, i0, q0}), 64'({m_e.uf, m_e.i0, m_e.q0}));
            chk("hold_policy_out", 64'({uf1, i1, q1}), 64'({m_e.uf, m_e.i1, m_e.q1}));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push1(input logic [7:0] b);
      fq.push_back(b);
   endtask

   task automatic push6(input logic [47:0] v);
      for (int k = 0; k < 6; k++) fq.push_back(v[47-8*k -: 8]);
   endtask

   task automatic exp_push(input logic uf, input logic [23:0] ei0, eq0, ei1, eq1);
      exp_t e;
      e.uf  = uf;
      e.i0  = ei0;
      e.q0  = eq0;
      e.i1  = ei1;
      e.q1  = eq1;
      e.cyc = cyc + 32'd1;
      exp_q.push_back(e);
   endtask

   task automatic sreq(input logic uf, input logic [23:0] ei0, eq0, ei1, eq1);
      sample_req = 1'b1;
      exp_push(uf, ei0, eq0, ei1, eq1);
      tick(1);
      sample_req = 1'b0;
   endtask

   task automatic xfer(input logic [23:0] ei, input logic [23:0] eq);
      sreq(1'b0, ei, eq, ei, eq);
      h_i = ei;
      h_q = eq;
   endtask

   task automatic uflow();
      sreq(1'b1, 24'h0, 24'h0, h_i, h_q);
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: got no end of stimulus, expected completion within time limit");
      summary();
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      run = 1'b1;
      sample_req = 1'b0;
      for (int k = 0; k < 4; k++) push1(8'hA0 + 8'(k));
      tick(2);
      chk("reset_rdreq", 64'(rdreq0), 64'(0));
      chk("reset_outputs", 64'({i0, q0}), 64'(0));
      chk("reset_strobes", 64'({sv0, uf0, sv1, uf1}), 64'(0));
      chk("reset_count", 64'(cnt0), 64'(0));
      rst_n = 1'b1;
      tick(8);
      chk("startup_drained", 64'(fq.size()), 64'(0));
      chk("waiting_idle", 64'(wt0), 64'(1));

      // Basic sample assembly and one-cycle latency.
      push6(48'h123456_ABCDEF);
      tick(9);
      xfer(24'h123456, 24'hABCDEF);
      tick(2);

      // Empty FIFO underflows.
      for (int k = 0; k < 3; k++) begin
         uflow();
         tick(1);
      end
      chk("uf_count_3", 64'(cnt0), 64'(3));
      chk("uf_count_3_hold", 64'(cnt1), 64'(3));

      // Pending full, next sample stalled on its last byte until the transfer.
      push6(48'h010203_040506);
      tick(9);
      push6(48'h111213_141516);
      tick(10);
      chk("stall_on_last_byte", 64'(fq.size()), 64'(1));
      chk("waiting_busy", 64'(wt0), 64'(0));
      xfer(24'h010203, 24'h040506);
      xfer(24'h111213, 24'h141516);
      tick(2);
      chk("reload_consumed", 64'(fq.size()), 64'(0));

      // Underflow with partial bytes collected keeps the partial.
      push6(48'h212223_000000);
      void'(fq.pop_back()); void'(fq.pop_back()); void'(fq.pop_back());
      tick(5);
      uflow();
      tick(2);
      push1(8'h24); push1(8'h25); push1(8'h26);
      tick(6);
      xfer(24'h212223, 24'h242526);
      tick(2);
      chk("uf_count_4", 64'(cnt0), 64'(4));

      // Run dropped mid-sample with a deep FIFO.
      push1(8'h31); push1(8'h32); push1(8'h33);
      tick(5);
      run = 1'b0;
      h_i = 24'h0;
      h_q = 24'h0;
      for (int k = 0; k < 20; k++) push1(8'h80 + 8'(k));
      tick(3);
      sreq(1'b1, 24'h0, 24'h0, 24'h0, 24'h0);
      tick(25);
      chk("flush_drained_20", 64'(fq.size()), 64'(0));
      chk("flush_out_zero", 64'({i0, q0}), 64'(0));
      chk("flush_out_zero_hold", 64'({i1, q1}), 64'(0));
      chk("flush_no_count", 64'(cnt0), 64'(4));
      run = 1'b1;
      tick(2);
      push6(48'h414243_444546);
      tick(9);
      xfer(24'h414243, 24'h444546);
      tick(2);

      // Asynchronous reset mid-sample, between clock edges.
      push6(48'h515253_545556);
      tick(9);
      push1(8'h61); push1(8'h62); push1(8'h63);
      tick(6);
      push1(8'hE1); push1(8'hE2);
      tick(1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_out", 64'({i0, q0}), 64'(0));
      chk("async_reset_out_hold", 64'({i1, q1}), 64'(0));
      chk("async_reset_rdreq", 64'(rdreq0), 64'(0));
      chk("async_reset_count", 64'(cnt0), 64'(0));
      tick(2);
      rst_n = 1'b1;
      h_i = 24'h0;
      h_q = 24'h0;
      tick(6);
      chk("post_reset_drained", 64'(fq.size()), 64'(0));
      push6(48'h717273_747576);
      tick(9);
      xfer(24'h717273, 24'h747576);
      tick(2);

      // Counter saturation with sample_req held high.
      sample_req = 1'b1;
      for (int k = 0; k < 65534; k++) begin
         exp_push(1'b1, 24'h0, 24'h0, h_i, h_q);
         tick(1);
      end
      chk("count_fffe", 64'(cnt0), 64'(16'hFFFE));
      for (int k = 0; k < 6; k++) begin
         exp_push(1'b1, 24'h0, 24'h0, h_i, h_q);
         tick(1);
      end
      sample_req = 1'b0;
      tick(2);
      chk("count_saturated", 64'(cnt0), 64'(16'hFFFF));
      chk("count_saturated_hold", 64'(cnt1), 64'(16'hFFFF));

      chk("expected_all_seen", 64'(exp_q.size()), 64'(0));
      chk("rdreq_while_empty", 64'(viol), 64'(0));
      summary();
      $finish;
   end

endmodule

// File: doc/tx_iq_byte_assembler.md
TX_IQ_BYTE_ASSEMBLER -- requirements
Module: tx_iq_byte_assembler

Interface
REQ-001 Parameter UF_HOLD, default 0: underflow policy; 0 outputs zero I/Q, 1 repeats last I/Q.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  Tx stream enabled; 0 forces flush.
REQ-005 fifo_rdata  input  8  Tx byte FIFO output; show-ahead, valid while fifo_empty=0.
REQ-006 fifo_empty  input  1  Tx byte FIFO empty.
REQ-007 fifo_rdreq  output  1  consume current FIFO byte; combinational.
REQ-008 sample_req  input  1  one-cycle strobe from DUC requesting next sample.
REQ-009 I_out  output  24  transmit I sample, registered.
REQ-010 Q_out  output  24  transmit Q sample, registered.
REQ-011 sample_valid  output  1  one-cycle strobe; I_out/Q_out updated.
REQ-012 underflow  output  1  one-cycle strobe; sample_req had no complete sample.
REQ-013 underflow_count  output  16  saturating underflow counter.
REQ-014 waiting  output  1  high when pending empty, byte index 0, FIFO empty, run=1.

Function
REQ-015 Byte order per sample: b0 I[23:16], b1 I[15:8], b2 I[7:0], b3 Q[23:16], b4 Q[15:8], b5 Q[7:0].
REQ-016 States: COLLECT, FLUSH; byte index 0..5; one pending register {pI,pQ} with pending_valid.
REQ-017 COLLECT, byte index 0..4: fifo_rdreq = !fifo_empty; on rdreq, byte stored, index increments.
REQ-018 COLLECT, index 5: fifo_rdreq = !fifo_empty && (!pending_valid || transfer this cycle); on rdreq pending loads assembled I/Q, pending_valid=1, index returns to 0.
REQ-019 Transfer: sample_req && pending_valid -> next edge I_out/Q_out = pending, sample_valid=1, pending_valid=0 unless reloaded same edge per REQ-018.
REQ-020 Latency sample_req to sample_valid: exactly 1 cycle; I_out/Q_out hold between transfers.
REQ-021 Underflow: sample_req && !pending_valid -> next edge underflow=1, sample_valid=1, I_out/Q_out = 0 (UF_HOLD=0) or unchanged (UF_HOLD=1); count +1, saturates at 16'hFFFF.
REQ-022 sample_req while partial bytes collected and pending empty: underflow per REQ-021; partial bytes retained.
REQ-023 run falling (any state, any index): next edge enters FLUSH, index=0, pending_valid=0, partial bytes discarded, I_out/Q_out=0.
REQ-024 FLUSH: fifo_rdreq = !fifo_empty; sample_req answered per REQ-021 with zero output regardless of UF_HOLD, counter not incremented.
REQ-025 FLUSH -> COLLECT when run=1 and fifo_empty=1, same edge; index 0.
REQ-026 fifo_rdreq never asserted while fifo_empty=1.
REQ-027 underflow_count clears only on reset.

Reset
REQ-028 Reset asserted: state FLUSH, index 0, pending_valid 0, I_out/Q_out 0, sample_valid 0, underflow 0, underflow_count 0.
REQ-029 fifo_rdreq held 0 while reset asserted; outputs take reset values asynchronously.
REQ-030 Reset released mid-stream: FIFO drained before first byte accepted, preserving 6-byte alignment.

Verification
REQ-031 run=1, FIFO bytes 12 34 56 AB CD EF, then sample_req -> next cycle I_out=123456, Q_out=ABCDEF, sample_valid=1.
REQ-032 Pending full, bytes b0..b5 of next sample queued, sample_req coincides with b5 -> b5 consumed same cycle, pending reloads, no stall or loss.
REQ-033 Empty FIFO, sample_req x3 with UF_HOLD=0 -> three underflow strobes, I/Q=0, count=3; UF_HOLD=1 -> I/Q equal last sample.
REQ-034 run dropped after 3 bytes, FIFO holds 20 bytes -> all 20 drained, partial discarded, outputs 0; run=1 with new 6 bytes -> correct aligned sample.
REQ-035 Force 65536 underflows -> underflow_count saturates at FFFF.
REQ-036 Reset asserted mid-sample, async to clock -> outputs zero immediately, rdreq 0; after release FIFO flushed before collection.
